// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for the CORDIC multiplier arbiter.
// Holds the FSM state encoding, default timing constants and the operand slicer.
package cordic_arb_pkg;

  localparam int DEFAULT_MUL_ITERS = 16;
  localparam int DEFAULT_TIMEOUT   = 32;
  localparam int MAX_BUS_W         = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_e;

  // Picks requester idx's 8-bit operand out of a packed bus (zero-extended to MAX_BUS_W).
  function automatic logic [7:0] opSlice(input logic [MAX_BUS_W-1:0] bus, input int idx);
    return bus[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/cordic_mul_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request
// found searching upward from ptr_i+1, wrapping modulo NUM_REQ.
module rr_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/cordic_mul_arbiter.sv
// Round-robin scheduler sharing one sequential CORDIC multiplier among NUM_REQ
// requesters, with operand hold, done watchdog and a single result port.
module cordic_mul_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int MUL_ITERS = DEFAULT_MUL_ITERS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_x,
  input  logic [NUM_REQ*8-1:0] req_z,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_y,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [7:0]           mul_x,
  output logic [7:0]           mul_z,
  input  logic [15:0]          mul_y,
  input  logic                 mul_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT <= MUL_ITERS + 1) begin : gBadTimeout
    $error("TIMEOUT must exceed MUL_ITERS+1");
  end

  state_e            state_q;
  logic [ID_W-1:0]   rrPtr_q;
  logic [WD_W-1:0]   wdCnt_q;
  logic [WD_W-1:0]   wdCnt_d;
  logic              mulStart_q;
  logic [7:0]        mulX_q;
  logic [7:0]        mulZ_q;
  logic              resValid_q;
  logic [15:0]       resY_q;
  logic [ID_W-1:0]   resId_q;
  logic              resErr_q;

  logic [NUM_REQ-1:0] arbGrant;
  logic [ID_W-1:0]    arbId;
  logic               arbAny;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) uArb (
    .req_i   (req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (arbGrant),
    .id_o    (arbId),
    .any_o   (arbAny)
  );

  assign wdCnt_d   = wdCnt_q + 1'b1;
  assign req_ready = (state_q == IDLE) ? arbGrant : '0;
  assign busy      = (state_q != IDLE);
  assign mul_start = mulStart_q;
  assign mul_x     = mulX_q;
  assign mul_z     = mulZ_q;
  assign res_valid = resValid_q;
  assign res_y     = resY_q;
  assign res_id    = resId_q;
  assign res_err   = resErr_q;

  // rrPtr_q doubles as the id of the granted requester for the current run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      wdCnt_q    <= '0;
      mulStart_q <= 1'b0;
      mulX_q     <= '0;
      mulZ_q     <= '0;
      resValid_q <= 1'b0;
      resY_q     <= '0;
      resId_q    <= '0;
      resErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arbAny) begin
            mulX_q     <= opSlice(MAX_BUS_W'(req_x), int'(arbId));
            mulZ_q     <= opSlice(MAX_BUS_W'(req_z), int'(arbId));
            rrPtr_q    <= arbId;
            wdCnt_q    <= '0;
            mulStart_q <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          wdCnt_q <= wdCnt_d;
          if (mul_done) begin
            resY_q     <= mul_y;
            resId_q    <= rrPtr_q;
            resErr_q   <= 1'b0;
            resValid_q <= 1'b1;
            mulStart_q <= 1'b0;
            state_q    <= RESP;
          end else if (wdCnt_q == WD_W'(TIMEOUT - 1)) begin
            resY_q     <= '0;
            resId_q    <= rrPtr_q;
            resErr_q   <= 1'b1;
            resValid_q <= 1'b1;
            mulStart_q <= 1'b0;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_mul_arbiter.sv
// Randomized self-checking bench for cordic_mul_arbiter with a stub multiplier
// and a transaction-level round-robin/latency reference model.
module tb_cordic_mul_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int TIMEOUT   = 32;
  localparam int MUL_ITERS = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_x;
  logic [NUM_REQ*8-1:0] req_z;
  logic                 res_valid;
  logic                 res_ready;
  logic [15:0]          res_y;
  logic [ID_W-1:0]      res_id;
  logic                 res_err;
  logic                 busy;
  logic                 mul_start;
  logic [7:0]           mul_x;
  logic [7:0]           mul_z;
  logic [15:0]          mul_y;
  logic                 mul_done;

  int  total = 0;
  int  bad   = 0;
  int  lastId = 0;
  int  cyc = 0;
  int  stubCnt = 0;
  logic tieDoneLow = 1'b0;
  logic signed [15:0] stubProd;

  cordic_mul_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ID_W      (ID_W),
    .TIMEOUT   (TIMEOUT),
    .MUL_ITERS (MUL_ITERS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_z     (req_z),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_id    (res_id),
    .res_err   (res_err),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_x     (mul_x),
    .mul_z     (mul_z),
    .mul_y     (mul_y),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub multiplier: counts edges while start is high, done after MUL_ITERS edges.
  always @(posedge clk) begin
    if (!mul_start) stubCnt <= 0;
    else if (stubCnt < MUL_ITERS) stubCnt <= stubCnt + 1;
  end
  assign stubProd = $signed(mul_x) * $signed(mul_z);
  assign mul_done = !tieDoneLow && mul_start && (stubCnt == MUL_ITERS);
  assign mul_y    = mul_done ? stubProd : 16'hDEAD;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nextGrant(input int last, input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // One full transaction from IDLE: grant, run, optional stall, handshake.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input bit dead, input int stall);
    byte ex, ez;
    int expId, runCycles, waitCnt, p;
    bit held, stable;
    logic [15:0] expY, y0;
    logic [ID_W-1:0] id0;
    logic e0;
    tieDoneLow = dead;
    res_ready  = 1'b0;
    req_valid  = mask;
    req_x      = $urandom;
    req_z      = $urandom;
    expId      = nextGrant(lastId, mask);
    #1;
    checkOutput("grant", 32'(req_ready), 32'(1 << expId));
    ex = req_x[expId*8 +: 8];
    ez = req_z[expId*8 +: 8];
    p  = ex * ez;
    expY = dead ? 16'h0 : p[15:0];
    lastId = expId;
    @(negedge clk);
    req_valid = '0;
    req_x = $urandom;
    req_z = $urandom;
    runCycles = 0;
    held = 1'b1;
    waitCnt = 0;
    while (!res_valid && waitCnt < 60) begin
      if (mul_start) runCycles++;
      if (mul_x !== ex || mul_z !== ez) held = 1'b0;
      if (waitCnt == 5) begin
        req_x = $urandom;
        req_z = $urandom;
      end
      waitCnt++;
      @(negedge clk);
    end
    checkOutput("res_valid", 32'(res_valid), 32'd1);
    checkOutput("run_cycles", runCycles, dead ? TIMEOUT : MUL_ITERS + 1);
    checkOutput("op_hold", 32'(held), 32'd1);
    checkOutput("res_id", 32'(res_id), expId);
    checkOutput("res_err", 32'(res_err), 32'(dead));
    checkOutput("res_y", 32'(res_y), 32'(expY));
    checkOutput("resp_start_busy", {30'd0, mul_start, busy}, 32'd1);
    y0 = res_y;
    id0 = res_id;
    e0 = res_err;
    stable = 1'b1;
    req_valid = 4'($urandom_range(1, 15));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_y !== y0 || res_id !== id0 || res_err !== e0 ||
          req_ready !== '0 || mul_start !== 1'b0) stable = 1'b0;
    end
    if (stall > 0) checkOutput("stall_stable", 32'(stable), 32'd1);
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("res_drop", {30'd0, res_valid, busy}, 32'd0);
    res_ready = 1'b0;
    tieDoneLow = 1'b0;
  endtask

  // All requesters continuously valid: check order, period and start gap.
  task automatic applyStream(input int n);
    int got, lastCyc, want, w;
    bit low;
    req_valid = '1;
    res_ready = 1'b1;
    req_x = $urandom;
    req_z = $urandom;
    got = 0;
    lastCyc = -1;
    low = 1'b0;
    for (int c = 0; c < 40 * n && got < n; c++) begin
      #1;
      if (req_ready !== '0) begin
        want = nextGrant(lastId, '1);
        checkOutput("rr_order", 32'(req_ready), 32'(1 << want));
        lastId = want;
        if (lastCyc >= 0) begin
          checkOutput("period", cyc - lastCyc, 19);
          checkOutput("start_gap", 32'(low), 32'd1);
        end
        lastCyc = cyc;
        low = 1'b0;
        got++;
        if (got == n) req_valid = '0;
        req_x = $urandom;
        req_z = $urandom;
      end else if (lastCyc >= 0 && !mul_start) begin
        low = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("stream_count", got, n);
    req_valid = '0;
    w = 0;
    while (busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput("stream_flush", 32'(busy), 32'd0);
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_z = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_res", {res_valid, res_err, res_id, res_y}, 32'd0);
    checkOutput("rst_mul", {mul_start, mul_x, mul_z}, 32'd0);
    checkOutput("rst_busy_ready", {busy, req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStream(5);
    applyStimulus(4'b0100, 1'b0, 0);
    applyStimulus(4'b0100, 1'b0, 10);
    applyStimulus(4'b0010, 1'b1, 0);
    applyStimulus(4'b1111, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'($urandom_range(1, 15)), ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
    end

    req_valid = 4'b1000;
    req_x = $urandom;
    req_z = $urandom;
    @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);
    checkOutput("pre_reset_run", {31'd0, mul_start}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_abort", {29'd0, mul_start, res_valid, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lastId = 0;
    @(negedge clk);
    applyStimulus(4'b1111, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
